esl_retune_sequencer: RTL

//   Sequences configuration changes into the ESL phase generator (carrier NCO, modulation

---
 rtl/esl_retune_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/esl_retune_sequencer.sv
// Glitch-free reconfiguration sequencer for the ESL phase generator: ramp amplitudes to zero,
// load the new tuning words, wait out the generator pipeline, then ramp up to the new targets.
module esl_retune_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned AMP_W         = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [31:0]      cfg_f,
    input  logic [7:0]       cfg_multiplier,
    input  logic [21:0]      cfg_phase,
    input  logic [19:0]      cfg_phase_pdh,
    input  logic [AMP_W-1:0] cfg_i_amp,
    input  logic [AMP_W-1:0] cfg_q_amp,
    input  logic             cfg_clr,
    input  logic [AMP_W-1:0] cfg_ramp_step,
    input  logic             commit_valid,
    output logic             commit_ready,
    output logic [31:0]      f,
    output logic [7:0]       multiplier,
    output logic [21:0]      phase,
    output logic [19:0]      phase_pdh,
    output logic [AMP_W-1:0] i_amp,
    output logic [AMP_W-1:0] q_amp,
    output logic             clr,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRampDown,
        StLoad,
        StSettle,
        StRampUp
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shadow copies of the committed configuration
    logic [31:0]      sh_f_q, sh_f_d;
    logic [7:0]       sh_mult_q, sh_mult_d;
    logic [21:0]      sh_phase_q, sh_phase_d;
    logic [19:0]      sh_pdh_q, sh_pdh_d;
    logic [AMP_W-1:0] sh_i_q, sh_i_d;
    logic [AMP_W-1:0] sh_q_q, sh_q_d;
    logic             sh_clr_q, sh_clr_d;
    logic [AMP_W-1:0] sh_step_q, sh_step_d;

    logic [31:0]      f_q, f_d;
    logic [7:0]       mult_q, mult_d;
    logic [21:0]      phase_q, phase_d;
    logic [19:0]      pdh_q, pdh_d;
    logic [AMP_W-1:0] i_q, i_d;
    logic [AMP_W-1:0] q_q, q_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;

    logic [AMP_W-1:0] i_down, q_down, i_up, q_up;
    logic [AMP_W:0]   i_sum, q_sum;

    always_comb begin
        i_down = (i_q > sh_step_q) ? (i_q - sh_step_q) : '0;
        q_down = (q_q > sh_step_q) ? (q_q - sh_step_q) : '0;
        // One extra bit so the upward step cannot wrap past the target
        i_sum  = {1'b0, i_q} + {1'b0, sh_step_q};
        q_sum  = {1'b0, q_q} + {1'b0, sh_step_q};
        i_up   = (i_sum >= {1'b0, sh_i_q}) ? sh_i_q : i_sum[AMP_W-1:0];
        q_up   = (q_sum >= {1'b0, sh_q_q}) ? sh_q_q : q_sum[AMP_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_f_d     = sh_f_q;
        sh_mult_d  = sh_mult_q;
        sh_phase_d = sh_phase_q;
        sh_pdh_d   = sh_pdh_q;
        sh_i_d     = sh_i_q;
        sh_q_d     = sh_q_q;
        sh_clr_d   = sh_clr_q;
        sh_step_d  = sh_step_q;
        f_d        = f_q;
        mult_d     = mult_q;
        phase_d    = phase_q;
        pdh_d      = pdh_q;
        i_d        = i_q;
        q_d        = q_q;
        clr_d      = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (commit_valid) begin
                    sh_f_d     = cfg_f;
                    sh_mult_d  = cfg_multiplier;
                    sh_phase_d = cfg_phase;
                    sh_pdh_d   = cfg_phase_pdh;
                    sh_i_d     = cfg_i_amp;
                    sh_q_d     = cfg_q_amp;
                    sh_clr_d   = cfg_clr;
                    // A zero step means "jump straight there"
                    sh_step_d  = (cfg_ramp_step == '0) ? '1 : cfg_ramp_step;
                    state_d    = StRampDown;
                end
            end
            StRampDown: begin
                i_d = i_down;
                q_d = q_down;
                if (i_down == '0 && q_down == '0) begin
                    f_d     = sh_f_q;
                    mult_d  = sh_mult_q;
                    phase_d = sh_phase_q;
                    pdh_d   = sh_pdh_q;
                    clr_d   = sh_clr_q;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = SETTLE_LAST;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StRampUp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRampUp: begin
                i_d = i_up;
                q_d = q_up;
                if (i_up == sh_i_q && q_up == sh_q_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sh_f_q     <= '0;
            sh_mult_q  <= '0;
            sh_phase_q <= '0;
            sh_pdh_q   <= '0;
            sh_i_q     <= '0;
            sh_q_q     <= '0;
            sh_clr_q   <= 1'b0;
            sh_step_q  <= '0;
            f_q        <= '0;
            mult_q     <= '0;
            phase_q    <= '0;
            pdh_q      <= '0;
            i_q        <= '0;
            q_q        <= '0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_f_q     <= sh_f_d;
            sh_mult_q  <= sh_mult_d;
            sh_phase_q <= sh_phase_d;
            sh_pdh_q   <= sh_pdh_d;
            sh_i_q     <= sh_i_d;
            sh_q_q     <= sh_q_d;
            sh_clr_q   <= sh_clr_d;
            sh_step_q  <= sh_step_d;
            f_q        <= f_d;
            mult_q     <= mult_d;
            phase_q    <= phase_d;
            pdh_q      <= pdh_d;
            i_q        <= i_d;
            q_q        <= q_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
        end
    end

    assign commit_ready = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign f            = f_q;
    assign multiplier   = mult_q;
    assign phase        = phase_q;
    assign phase_pdh    = pdh_q;
    assign i_amp        = i_q;
    assign q_amp        = q_q;
    assign clr          = clr_q;
    assign done         = done_q;

endmodule
